// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time checks for the FIFO controller.
package fifo_pkg;

    // Occupancy needs one bit more than the address to represent DEPTH itself.
    function automatic int count_width(input int addr);
        return addr + 1;
    endfunction

    // The pointer wrap arithmetic only works when DEPTH fills the address space.
    function automatic bit depth_ok(input int depth, input int addr);
        return (addr > 0) && (depth == (1 << addr));
    endfunction

    // Threshold ranges: almost_full in 1..DEPTH, almost_empty in 0..DEPTH-1.
    function automatic bit levels_ok(input int depth, input int af_level, input int ae_level);
        return (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: ADDR+1 bit counter (address plus wrap bit) with increment enable.
module fifo_ptr #(
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc_i,
    output logic [ADDR-1:0] addr_o
);

    logic [ADDR:0] ptr_q;
    logic [ADDR:0] ptr_d;

    // Next pointer: advance by one, wrapping modulo 2**(ADDR+1).
    always_comb begin
        // NOTE: default assignment first so no path leaves ptr_d unassigned (no latch).
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + (ADDR+1)'(1);
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for state so all flops update from pre-edge values.
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign addr_o = ptr_q[ADDR-1:0];

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, status flags, sticky errors.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int ADDR     = 10,
    parameter int AF_LEVEL = 1020,
    parameter int AE_LEVEL = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_req,
    input  logic                        rd_req,
    output logic                        mem_wr_en,
    output logic [ADDR-1:0]             mem_wr_addr,
    output logic                        mem_rd_en,
    output logic [ADDR-1:0]             mem_rd_addr,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [count_width(ADDR)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int CW = count_width(ADDR);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (!depth_ok(DEPTH, ADDR)) begin : g_bad_depth
        $error("fifo_ctrl: DEPTH must equal 2**ADDR");
    end
    if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
        $error("fifo_ctrl: AF_LEVEL or AE_LEVEL out of range");
    end

    logic          wr_acc;
    logic          rd_acc;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          empty_q;
    logic          af_q;
    logic          ae_q;
    logic          rd_valid_q;
    logic          overflow_q;
    logic          underflow_q;

    // Accept decisions use only registered flags, so there is no fall-through path.
    assign wr_acc = wr_req & ~full_q;
    assign rd_acc = rd_req & ~empty_q;

    assign mem_wr_en = wr_acc;
    assign mem_rd_en = rd_acc;

    fifo_ptr #(.ADDR(ADDR)) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (wr_acc),
        .addr_o (mem_wr_addr)
    );

    fifo_ptr #(.ADDR(ADDR)) u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (rd_acc),
        .addr_o (mem_rd_addr)
    );

    // Next occupancy; the accept rules keep it within 0..DEPTH.
    assign count_d = count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};

    // Occupancy, flags derived from next occupancy, read-valid and sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            full_q      <= (count_d == DEPTH_C);
            empty_q     <= (count_d == '0);
            af_q        <= (count_d >= AF_C);
            ae_q        <= (count_d <= AE_C);
            rd_valid_q  <= rd_acc;
            overflow_q  <= overflow_q | (wr_req & full_q);
            underflow_q <= underflow_q | (rd_req & empty_q);
        end
    end

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign rd_valid     = rd_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with DEPTH=8, ADDR=3, AF_LEVEL=6, AE_LEVEL=1.
module tb_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int ADDR  = 3;

    logic             clk;
    logic             rst;
    logic             wr_req;
    logic             rd_req;
    logic             mem_wr_en;
    logic [ADDR-1:0]  mem_wr_addr;
    logic             mem_rd_en;
    logic [ADDR-1:0]  mem_rd_addr;
    logic             rd_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [ADDR:0]    count;
    logic             overflow;
    logic             underflow;

    fifo_ctrl #(
        .DEPTH    (DEPTH),
        .ADDR     (ADDR),
        .AF_LEVEL (6),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // One vector: inputs for this cycle and the outputs expected before the edge.
    typedef struct {
        logic rst, wr, rd;
        logic wen; int waddr; logic ren; int raddr; logic rv;
        int   cnt;
        logic full, empty, af, ae, ovf, udf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic w, input logic d,
                       input logic wen, input int waddr, input logic ren, input int raddr,
                       input logic rv, input int cnt, input logic fu, input logic em,
                       input logic af, input logic ae, input logic ovf, input logic udf);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = d;
        v.wen = wen; v.waddr = waddr; v.ren = ren; v.raddr = raddr; v.rv = rv;
        v.cnt = cnt; v.full = fu; v.empty = em; v.af = af; v.ae = ae;
        v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge and let combinational outputs settle.
    task automatic drive(input logic r, input logic w, input logic d);
        rst = r; wr_req = w; rd_req = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_n(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
        @(posedge clk);
        #1;

        //    r  w  d  wen wa ren ra rv cnt fu em af ae ov ud
        // Idle after reset
        add(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        // Fill to full
        add(0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0,  1, 2, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 3, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 4, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 5, 0, 0, 0, 5,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 6, 0, 0, 0, 6,  0, 0, 1, 0, 0, 0);
        add(0, 1, 0,  1, 7, 0, 0, 0, 7,  0, 0, 1, 0, 0, 0);
        // Ninth push is rejected
        add(0, 1, 0,  0, 0, 0, 0, 0, 8,  1, 0, 1, 0, 0, 0);
        // Drain
        add(0, 0, 1,  0, 0, 1, 0, 0, 8,  1, 0, 1, 0, 1, 0);
        add(0, 0, 1,  0, 0, 1, 1, 1, 7,  0, 0, 1, 0, 1, 0);
        add(0, 0, 1,  0, 0, 1, 2, 1, 6,  0, 0, 1, 0, 1, 0);
        add(0, 0, 1,  0, 0, 1, 3, 1, 5,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  0, 0, 1, 4, 1, 4,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  0, 0, 1, 5, 1, 3,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  0, 0, 1, 6, 1, 2,  0, 0, 0, 0, 1, 0);
        add(0, 0, 1,  0, 0, 1, 7, 1, 1,  0, 0, 0, 1, 1, 0);
        // Extra pop is rejected
        add(0, 0, 1,  0, 0, 0, 0, 1, 0,  0, 1, 0, 1, 1, 0);
        add(0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1);
        // Reset clears the sticky errors
        add(1, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1);
        // Wrap-around: push 5
        add(0, 1, 0,  1, 0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 0);
        add(0, 1, 0,  1, 1, 0, 0, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0,  1, 2, 0, 0, 0, 2,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 3, 0, 0, 0, 3,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 4, 0, 0, 0, 4,  0, 0, 0, 0, 0, 0);
        // pop 5
        add(0, 0, 1,  0, 5, 1, 0, 0, 5,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 5, 1, 1, 1, 4,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 5, 1, 2, 1, 3,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 5, 1, 3, 1, 2,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 5, 1, 4, 1, 1,  0, 0, 0, 1, 0, 0);
        // push 6 across the address wrap
        add(0, 1, 0,  1, 5, 0, 5, 1, 0,  0, 1, 0, 1, 0, 0);
        add(0, 1, 0,  1, 6, 0, 5, 0, 1,  0, 0, 0, 1, 0, 0);
        add(0, 1, 0,  1, 7, 0, 5, 0, 2,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 0, 0, 5, 0, 3,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 1, 0, 5, 0, 4,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0,  1, 2, 0, 5, 0, 5,  0, 0, 0, 0, 0, 0);
        // pop 6 across the address wrap
        add(0, 0, 1,  0, 3, 1, 5, 0, 6,  0, 0, 1, 0, 0, 0);
        add(0, 0, 1,  0, 3, 1, 6, 1, 5,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 3, 1, 7, 1, 4,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 3, 1, 0, 1, 3,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 3, 1, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1,  0, 3, 1, 2, 1, 1,  0, 0, 0, 1, 0, 0);
        add(0, 0, 0,  0, 3, 0, 3, 1, 0,  0, 1, 0, 1, 0, 0);
        add(0, 0, 0,  0, 3, 0, 3, 0, 0,  0, 1, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].rd);
            check($sformatf("v%0d.mem_wr_en", i),    32'(mem_wr_en),    32'(vecs[i].wen));
            check($sformatf("v%0d.mem_wr_addr", i),  32'(mem_wr_addr),  vecs[i].waddr);
            check($sformatf("v%0d.mem_rd_en", i),    32'(mem_rd_en),    32'(vecs[i].ren));
            check($sformatf("v%0d.mem_rd_addr", i),  32'(mem_rd_addr),  vecs[i].raddr);
            check($sformatf("v%0d.rd_valid", i),     32'(rd_valid),     32'(vecs[i].rv));
            check($sformatf("v%0d.count", i),        32'(count),        vecs[i].cnt);
            check($sformatf("v%0d.full", i),         32'(full),         32'(vecs[i].full));
            check($sformatf("v%0d.empty", i),        32'(empty),        32'(vecs[i].empty));
            check($sformatf("v%0d.almost_full", i),  32'(almost_full),  32'(vecs[i].af));
            check($sformatf("v%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
            check($sformatf("v%0d.overflow", i),     32'(overflow),     32'(vecs[i].ovf));
            check($sformatf("v%0d.underflow", i),    32'(underflow),    32'(vecs[i].udf));
            tick();
        end

        // Push and pop together while empty: push wins, no fall-through.
        do_reset();
        drive(1'b0, 1'b1, 1'b1);
        check("se.mem_wr_en", 32'(mem_wr_en), 1);
        check("se.mem_rd_en", 32'(mem_rd_en), 0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("se.count", 32'(count), 1);
        check("se.empty", 32'(empty), 0);
        check("se.rd_valid", 32'(rd_valid), 0);
        check("se.underflow", 32'(underflow), 1);
        tick();
        check("se.rd_valid_later", 32'(rd_valid), 0);

        // Push and pop together while full: pop wins, overflow sets.
        push_n(7);
        check("sf.full_before", 32'(full), 1);
        drive(1'b0, 1'b1, 1'b1);
        check("sf.mem_wr_en", 32'(mem_wr_en), 0);
        check("sf.mem_rd_en", 32'(mem_rd_en), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("sf.count", 32'(count), 7);
        check("sf.full", 32'(full), 0);
        check("sf.overflow", 32'(overflow), 1);
        check("sf.rd_valid", 32'(rd_valid), 1);

        // Push and pop together at count=3: count holds, both pointers advance.
        do_reset();
        push_n(3);
        drive(1'b0, 1'b1, 1'b1);
        check("s3.mem_wr_en", 32'(mem_wr_en), 1);
        check("s3.mem_rd_en", 32'(mem_rd_en), 1);
        check("s3.mem_wr_addr", 32'(mem_wr_addr), 3);
        check("s3.mem_rd_addr", 32'(mem_rd_addr), 0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("s3.count", 32'(count), 3);
        check("s3.mem_wr_addr_next", 32'(mem_wr_addr), 4);
        check("s3.mem_rd_addr_next", 32'(mem_rd_addr), 1);

        // Reset mid-burst with rd_req held: reset wins, rd_valid stays low.
        do_reset();
        push_n(5);
        drive(1'b0, 1'b0, 1'b1);
        tick();
        check("rm.count_before", 32'(count), 4);
        drive(1'b1, 1'b0, 1'b1);
        check("rm.mem_rd_en_in_reset", 32'(mem_rd_en), 1);
        tick();
        drive(1'b0, 1'b0, 1'b1);
        check("rm.count", 32'(count), 0);
        check("rm.empty", 32'(empty), 1);
        check("rm.rd_valid", 32'(rd_valid), 0);
        check("rm.mem_wr_addr", 32'(mem_wr_addr), 0);
        check("rm.mem_rd_addr", 32'(mem_rd_addr), 0);
        check("rm.mem_rd_en", 32'(mem_rd_en), 0);
        drive(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
Single-clock pointer and flag controller for the dual-port FIFO memory. It accepts push/pop requests and drives the memory's write-enable, read-enable and address ports. It keeps the occupancy count and reports full, empty, almost-full and almost-empty status, plus sticky overflow and underflow errors. Its read-valid strobe lines up with the memory's one-cycle registered read, so the controller and the memory together form the complete synchronous FIFO.

Parameters:
- DEPTH, 1024: number of entries; must equal 2**ADDR.
- ADDR, 10: memory address width.
- AF_LEVEL, 1020: almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 4: almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk, input, 1: single clock; the top level drives both wr_clk and rd_clk of the memory from it.
- rst, input, 1: synchronous reset, active-high; the top level drives memory rst_n = ~rst.
- wr_req, input, 1: push request.
- rd_req, input, 1: pop request.
- mem_wr_en, output, 1: memory write enable (combinational).
- mem_wr_addr, output, ADDR: memory write address.
- mem_rd_en, output, 1: memory read enable (combinational).
- mem_rd_addr, output, ADDR: memory read address.
- rd_valid, output, 1: memory rd_data holds popped data this cycle.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AF_LEVEL.
- almost_empty, output, 1: count <= AE_LEVEL.
- count, output, ADDR+1: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a push was rejected.
- underflow, output, 1: sticky; a pop was rejected.

Behaviour:
- Reset (rst high at a clk edge):
  - wr_ptr, rd_ptr and count go to 0.
  - empty=1, almost_empty=1 (AE_LEVEL>=0).
  - full=0, almost_full=0, rd_valid=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
- Pointers are ADDR+1 bits wide. The low ADDR bits are the address; the MSB is the wrap bit. Pointers increment modulo 2**(ADDR+1), so address DEPTH-1 wraps naturally to 0.
- Accept rules, evaluated on registered flags:
  - wr_acc = wr_req & ~full
  - rd_acc = rd_req & ~empty
- Memory drive:
  - mem_wr_en = wr_acc; mem_wr_addr = wr_ptr[ADDR-1:0].
  - mem_rd_en = rd_acc; mem_rd_addr = rd_ptr[ADDR-1:0].
- Pointer update: on wr_acc, wr_ptr += 1; on rd_acc, rd_ptr += 1.
- Count update: count_next = count + wr_acc - rd_acc, evaluated in ADDR+1 bits; it never exceeds DEPTH and never goes below 0.
- All flags are registered and derived from count_next, so each flag is valid in the cycle after the causing edge.
- Simultaneous push and pop:
  - Full: the pop is accepted and the push is rejected (overflow sets); full deasserts next cycle.
  - Empty: the push is accepted and the pop is rejected (underflow sets). There is no fall-through; the data becomes readable next cycle.
  - Otherwise both are accepted and count is unchanged.
- Read latency: rd_valid is rd_acc registered, i.e. high exactly one cycle after mem_rd_en, which is when the memory's rd_data updates.
- Read-during-write to the same address cannot occur. An address is only readable when count > 0, and writes target only free slots.
- Error flags:
  - overflow sets on wr_req & full; underflow sets on rd_req & empty.
  - Both clear only on reset. Rejected requests change no other state.
- Reset mid-operation: the reset wins over any concurrent request. rd_valid is 0 in the following cycle even if a read was issued in the reset cycle.

Decomposition:
- Shared package fifo_pkg holds:
  - the ADDR/DEPTH relation check (DEPTH == 2**ADDR);
  - the count width constant (ADDR+1);
  - a localparam function for the level-range checks.
- The natural sub-module is fifo_ptr, instantiated twice (write and read). It contains the ADDR+1 pointer register with an increment enable and a synchronous reset.
- A top-level sync_fifo instantiates fifo_ctrl and fifo_mem; it is outside this block's scope.

Test Plan:
- Reset, then idle for 3 cycles:
  - empty=1, full=0, count=0, rd_valid=0, overflow=0, underflow=0, mem_wr_en=mem_rd_en=0.
- Fill to full (DEPTH=8, ADDR=3, AF_LEVEL=6, AE_LEVEL=1): push 8 times.
  - mem_wr_addr steps 0..7; count ends at 8; full=1.
  - almost_full rises after the 6th push; almost_empty falls after the 2nd push.
  - A 9th push gives mem_wr_en=0 and overflow=1.
- Drain and read latency: pop 8 times from full.
  - mem_rd_addr steps 0..7; rd_valid trails each mem_rd_en by exactly 1 cycle.
  - empty=1 after the last pop; an extra pop gives mem_rd_en=0 and underflow=1.
- Wrap-around: push 5, pop 5, push 6, pop 6.
  - Write addresses run 5,6,7,0,1,2; read addresses match in order; count returns to 0.
- Simultaneous events:
  - Push+pop while empty: count goes to 1 with no rd_valid.
  - Push+pop while full: count=7, overflow=1.
  - Push+pop at count=3: count stays 3 and both addresses advance.
- Reset mid-burst: at count=5 with rd_req held, assert rst for 1 cycle.
  - Next cycle: count=0, empty=1, rd_valid=0, and both pointers restart at address 0.
